// File: rtl/memory_responder.sv
// Word-addressed on-chip memory that terminates the shared memory bus.
// It serves one request at a time, with a fixed latency and a registered single-cycle ready.
module memory_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        memory_valid,
  input  logic        memory_instr,
  input  logic [31:0] memory_addr,
  input  logic [31:0] memory_wdata,
  input  logic [3:0]  memory_wstrb,
  output logic [31:0] memory_rdata,
  output logic        memory_ready,
  output logic        memory_error
);

  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] DEPTH_U = DEPTH_WORDS;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic        instr_q, instr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        ready_q, ready_d;
  logic        error_q, error_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

  logic          accept;
  logic          complete;
  logic          bad;
  logic          do_write;
  logic [31:0]   offset;
  logic [AW-1:0] index;

  // State register; the captured request and the memory are data and are not reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ready_q <= ready_d;
      error_q <= error_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clock) begin
    instr_q <= instr_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    wstrb_q <= wstrb_d;
  end

  // Next state: a new request is taken in IDLE and also in the ready cycle
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    accept  = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        if (memory_valid) begin
          accept  = 1'b1;
          count_d = 4'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        count_d = count_q - 4'd1;
        if (count_q == 4'd1) state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  // The _d request is the live bus on an accept and the held copy otherwise
  always_comb begin
    instr_d = accept ? memory_instr : instr_q;
    addr_d  = accept ? memory_addr  : addr_q;
    wdata_d = accept ? memory_wdata : wdata_q;
    wstrb_d = accept ? memory_wstrb : wstrb_q;
  end

  // Outputs: the access executes on the edge that enters RESP
  always_comb begin
    complete = (state_d == RESP);
    offset   = addr_d - BASE_ADDR;
    index    = offset[AW+1:2];
    bad      = ((offset >> 2) >= DEPTH_U) || (instr_d && (wstrb_d != 4'h0));
    do_write = complete && !bad && (wstrb_d != 4'h0);
    ready_d  = complete;
    error_d  = complete && bad;
    rdata_d  = (complete && !bad && (wstrb_d == 4'h0)) ? mem[index] : 32'h0;
  end

  always_ff @(posedge clock) begin
    if (reset && do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_d[i]) mem[index][8*i +: 8] <= wdata_d[8*i +: 8];
      end
    end
  end

  assign memory_rdata = rdata_q;
  assign memory_ready = ready_q;
  assign memory_error = error_q;

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: four instances with different latency/base/depth share one request bus,
// and a word-array model of each memory predicts every response.
module tb_memory_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  valid;
  logic        instr;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata [4];
  logic [3:0]  ready, error;

  int          lat   [4] = '{1, 2, 3, 4};
  logic [31:0] base  [4] = '{32'h0, 32'h1000, 32'h0, 32'h0};
  int          depth [4] = '{1024, 16, 1024, 1024};
  bit   [31:0] model [4][1024];

  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_rdata;
  logic        last_error;

  always #5 clock = ~clock;

  memory_responder #(.BASE_ADDR(32'h0), .DEPTH_WORDS(1024), .LATENCY(1)) u0 (
    .clock(clock), .reset(reset), .memory_valid(valid[0]), .memory_instr(instr),
    .memory_addr(addr), .memory_wdata(wdata), .memory_wstrb(wstrb),
    .memory_rdata(rdata[0]), .memory_ready(ready[0]), .memory_error(error[0]));
  memory_responder #(.BASE_ADDR(32'h1000), .DEPTH_WORDS(16), .LATENCY(2)) u1 (
    .clock(clock), .reset(reset), .memory_valid(valid[1]), .memory_instr(instr),
    .memory_addr(addr), .memory_wdata(wdata), .memory_wstrb(wstrb),
    .memory_rdata(rdata[1]), .memory_ready(ready[1]), .memory_error(error[1]));
  memory_responder #(.BASE_ADDR(32'h0), .DEPTH_WORDS(1024), .LATENCY(3)) u2 (
    .clock(clock), .reset(reset), .memory_valid(valid[2]), .memory_instr(instr),
    .memory_addr(addr), .memory_wdata(wdata), .memory_wstrb(wstrb),
    .memory_rdata(rdata[2]), .memory_ready(ready[2]), .memory_error(error[2]));
  memory_responder #(.BASE_ADDR(32'h0), .DEPTH_WORDS(1024), .LATENCY(4)) u3 (
    .clock(clock), .reset(reset), .memory_valid(valid[3]), .memory_instr(instr),
    .memory_addr(addr), .memory_wdata(wdata), .memory_wstrb(wstrb),
    .memory_rdata(rdata[3]), .memory_ready(ready[3]), .memory_error(error[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: predicts the response and applies writes to the model
  function automatic void predict(input int k, input bit ins, input logic [31:0] a,
                                  input logic [31:0] w, input logic [3:0] s,
                                  output logic [31:0] er, output logic ee);
    logic [31:0] off;
    logic [31:0] idx;
    off = a - base[k];
    idx = off >> 2;
    ee  = (idx >= 32'(depth[k])) || (ins && s != 4'h0);
    er  = 32'h0;
    if (!ee) begin
      if (s == 4'h0) er = model[k][idx[9:0]];
      else for (int i = 0; i < 4; i++)
        if (s[i]) model[k][idx[9:0]][8*i +: 8] = w[8*i +: 8];
    end
  endfunction

  task automatic req(input int k, input bit ins, input logic [31:0] a,
                     input logic [31:0] w, input logic [3:0] s);
    logic [31:0] er;
    logic        ee;
    int          n;
    bit          got;
    predict(k, ins, a, w, s, er, ee);
    instr = ins; addr = a; wdata = w; wstrb = s;
    valid[k] = 1'b1;
    n = 0; got = 0;
    while (n < 20 && !got) begin
      @(posedge clock); n++;
      @(negedge clock);
      if (ready[k]) got = 1;
      else begin
        check("wait_rdata", rdata[k], 32'h0);
        check("wait_error", 32'(error[k]), 32'h0);
      end
    end
    if (!got) check("ready_timeout", 32'h0, 32'h1);
    else begin
      check("latency", 32'(n), 32'(lat[k]));
      check("rdata", rdata[k], er);
      check("error", 32'(error[k]), 32'(ee));
      last_rdata = rdata[k];
      last_error = error[k];
    end
    valid[k] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prior;
    reset = 1'b0; valid = 4'h0; instr = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;

    // Reset state and quiet idle
    for (int c = 0; c < 6; c++) begin
      for (int k = 0; k < 4; k++) begin
        check("idle_ready", 32'(ready[k]), 32'h0);
        check("idle_error", 32'(error[k]), 32'h0);
        check("idle_rdata", rdata[k], 32'h0);
      end
      @(posedge clock); @(negedge clock);
    end

    // LATENCY=3 write/read and byte strobes
    req(2, 0, 32'h10, 32'hDEADBEEF, 4'hF);
    req(2, 0, 32'h10, 32'h0, 4'h0);
    check("deadbeef", last_rdata, 32'hDEADBEEF);
    req(2, 0, 32'h10, 32'h000000AA, 4'h1);
    req(2, 0, 32'h10, 32'h55000000, 4'h8);
    req(2, 0, 32'h10, 32'h0, 4'h0);
    check("bytelanes", last_rdata, 32'h55ADBEAA);

    // LATENCY=1 back-to-back reads
    for (int i = 0; i < 4; i++) req(0, 0, 32'(4 * i), $urandom, 4'hF);
    instr = 0; wstrb = 4'h0; addr = 32'h0; valid[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); @(negedge clock);
      check("b2b_ready", 32'(ready[0]), 32'h1);
      check("b2b_rdata", rdata[0], model[0][i]);
      if (i < 3) addr = 32'(4 * (i + 1));
      else valid[0] = 1'b0;
    end
    @(posedge clock); @(negedge clock);
    check("b2b_ready_end", 32'(ready[0]), 32'h0);

    // Range and instruction-write errors (base 0x1000, 16 words)
    req(1, 0, 32'h1000, $urandom, 4'hF);
    req(1, 0, 32'h1040, 32'h0, 4'h0);
    check("err_hi", 32'(last_error), 32'h1);
    req(1, 0, 32'h0FFC, 32'h0, 4'h0);
    check("err_lo", 32'(last_error), 32'h1);
    check("err_lo_rdata", last_rdata, 32'h0);
    req(1, 1, 32'h1000, 32'hCAFEF00D, 4'hF);
    check("err_instr", 32'(last_error), 32'h1);
    req(1, 0, 32'h1000, 32'h0, 4'h0);

    // LATENCY=4 write aborted by reset in the second WAIT cycle
    prior = $urandom;
    req(3, 0, 32'h20, prior, 4'hF);
    instr = 0; addr = 32'h20; wdata = 32'h12345678; wstrb = 4'hF; valid[3] = 1'b1;
    @(posedge clock); @(negedge clock);
    check("abort_wait1", 32'(ready[3]), 32'h0);
    @(posedge clock); @(negedge clock);
    reset = 1'b0; valid[3] = 1'b0;
    @(posedge clock); @(negedge clock);
    check("abort_rst_ready", 32'(ready[3]), 32'h0);
    check("abort_rst_rdata", rdata[3], 32'h0);
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clock); @(negedge clock);
      check("abort_no_ready", 32'(ready[3]), 32'h0);
    end
    req(3, 0, 32'h20, 32'h0, 4'h0);
    check("abort_prior", last_rdata, prior);

    // Randomized traffic over all instances
    for (int t = 0; t < 60; t++) begin
      int          k;
      bit          ins;
      logic [31:0] a;
      logic [3:0]  s;
      k   = $urandom_range(0, 3);
      ins = ($urandom_range(0, 4) == 0);
      s   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      if (k == 1) a = 32'h0FF0 + 32'($urandom_range(0, 31) * 4) + 32'($urandom_range(0, 3));
      else        a = 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      req(k, ins, a, $urandom, s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
